// File: rtl/angle_fetch.sv
// angle_fetch: pulls projection angles from the host-side angle source one
// at a time, buffers them in a small show-ahead FIFO and hands them to the
// back-projection pipeline over a valid/ready interface. A scan runs
// IDLE -> FETCH -> DRAIN -> DONE and counts the angles delivered.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   start                   one-cycle scan request, honoured only in IDLE
//   hs_angle                angle currently offered by the host
//   hs_has_next_angle       host holds a valid angle on hs_angle
//   hs_next_angle_ack       host accepted hs_next_angle this cycle
//   hs_next_angle           consume the current host angle and advance
//   angle / angle_valid     FIFO head to the pipeline, valid when not empty
//   angle_ready             pipeline accepts angle this cycle
//   busy                    high in FETCH or DRAIN
//   done                    one-cycle pulse at end of scan
//   angle_count             angles handed to the pipeline this scan
module angle_fetch #(
  parameter int kAngleLength = 9,
  parameter int kFifoDepth   = 4,
  parameter int kCountLength = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [kAngleLength-1:0] hs_angle,
  input  logic                    hs_has_next_angle,
  input  logic                    hs_next_angle_ack,
  output logic                    hs_next_angle,
  output logic [kAngleLength-1:0] angle,
  output logic                    angle_valid,
  input  logic                    angle_ready,
  output logic                    busy,
  output logic                    done,
  output logic [kCountLength-1:0] angle_count
);

  localparam int kPtrLength = $clog2(kFifoDepth);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [kAngleLength-1:0] mem [kFifoDepth];
  logic [kPtrLength-1:0]   rd_ptr, wr_ptr;
  logic [kPtrLength:0]     occupancy;
  logic [kAngleLength-1:0] last_angle;
  logic                    fifo_empty, fifo_full;
  logic                    push, pop;

  assign fifo_empty = (occupancy == '0);
  assign fifo_full  = (occupancy == (kPtrLength+1)'(kFifoDepth));

  // Full gates the request even when a pop happens in the same cycle.
  assign hs_next_angle = (state == FETCH) && hs_has_next_angle && !fifo_full;
  assign push          = hs_next_angle && hs_next_angle_ack;
  assign pop           = !fifo_empty && angle_ready;

  // While empty the output keeps showing the last angle handed out, since the
  // slot under rd_ptr may hold stale data from an earlier wrap.
  assign angle       = fifo_empty ? last_angle : mem[rd_ptr];
  assign angle_valid = !fifo_empty;

  assign busy = (state == FETCH) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (!hs_has_next_angle) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Storage carries no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= hs_angle;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occupancy  <= '0;
      last_angle <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + kPtrLength'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + kPtrLength'(1);
        last_angle <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (kPtrLength+1)'(1);
        2'b01:   occupancy <= occupancy - (kPtrLength+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      angle_count <= '0;
    end else if ((state == IDLE) && start) begin
      angle_count <= '0;
    end else if (pop) begin
      angle_count <= angle_count + kCountLength'(1);
    end
  end

endmodule

// File: tb/tb_angle_fetch.sv
module tb_angle_fetch;

  localparam int kAngleLength = 9;
  localparam int kFifoDepth   = 4;
  localparam int kCountLength = 8;
  localparam int kMaxCycles   = 3000;

  logic                    clk;
  logic                    reset_n;
  logic                    start;
  logic [kAngleLength-1:0] hs_angle;
  logic                    hs_has_next_angle;
  logic                    hs_next_angle_ack;
  logic                    hs_next_angle;
  logic [kAngleLength-1:0] angle;
  logic                    angle_valid;
  logic                    angle_ready;
  logic                    busy;
  logic                    done;
  logic [kCountLength-1:0] angle_count;

  angle_fetch #(
    .kAngleLength(kAngleLength),
    .kFifoDepth  (kFifoDepth),
    .kCountLength(kCountLength)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .hs_angle         (hs_angle),
    .hs_has_next_angle(hs_has_next_angle),
    .hs_next_angle_ack(hs_next_angle_ack),
    .hs_next_angle    (hs_next_angle),
    .angle            (angle),
    .angle_valid      (angle_valid),
    .angle_ready      (angle_ready),
    .busy             (busy),
    .done             (done),
    .angle_count      (angle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Host source: hvals[0..hn-1] are offered with has_next=1; hvals[hn] sits on
  // the bus afterwards with has_next=0 and must never be taken.
  int hvals [300];
  int hn;
  int hidx;

  // Reference model of the scan: phase 0 idle, 1 fetch, 2 drain, 3 done.
  int phase;
  int q[$];
  int last_angle;
  int cnt;
  int pushes;
  logic saw_done;

  function automatic void model_reset();
    phase      = 0;
    q          = {};
    last_angle = 0;
    cnt        = 0;
  endfunction

  // Called just after a falling edge; drives inputs, checks, models the
  // coming rising edge and returns at the next falling edge.
  task automatic cycle(input logic st, input logic rdy, input logic ak);
    int  e_valid, e_angle, e_hsnext;
    logic hn_now;
    logic do_push, do_pop;
    start             = st;
    angle_ready       = rdy;
    hs_next_angle_ack = ak;
    hn_now            = (hidx < hn);
    hs_has_next_angle = hn_now;
    hs_angle          = kAngleLength'(hvals[hidx]);
    #1;
    e_valid  = (q.size() > 0);
    e_angle  = e_valid ? q[0] : last_angle;
    e_hsnext = (phase == 1) && hn_now && (q.size() < kFifoDepth);
    chk("angle_valid", int'(angle_valid), e_valid);
    chk("angle", int'(angle), e_angle);
    chk("hs_next_angle", int'(hs_next_angle), e_hsnext);
    chk("busy", int'(busy), int'((phase == 1) || (phase == 2)));
    chk("done", int'(done), int'(phase == 3));
    chk("angle_count", int'(angle_count), cnt);
    saw_done = done;
    do_push = (e_hsnext != 0) && ak;
    do_pop  = (e_valid != 0) && rdy;
    case (phase)
      0: if (st) begin phase = 1; cnt = 0; end
      1: if (!hn_now) phase = 2;
      2: if (q.size() == 0) phase = 3;
      default: phase = 0;
    endcase
    if (do_pop) begin
      last_angle = q.pop_front();
      cnt = (cnt + 1) % (1 << kCountLength);
    end
    if (do_push) begin
      q.push_back(hvals[hidx]);
      hidx++;
      pushes++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    int n;          // angles offered by the host
    int rnd;        // 1: random angle values, 0: 0,20,40,...
    int ready_pct;
    int ack_pct;
    int noise;      // stray start pulses while a scan is running
    int stall;      // angle_ready forced low for this many cycles
    int rst_after;  // assert reset after this many acks (0: never)
    int exp_count;  // angle_count at the end of the row
    int exp_done;   // cycle of the done pulse (-1: not checked)
  } row_t;

  row_t rows [9];

  task automatic run_row(input row_t r);
    int cyc;
    int dones;
    int done_cyc;
    logic finished;
    logic rdy, ak, st;
    hn = r.n;
    hidx = 0;
    for (int i = 0; i <= r.n; i++) begin
      hvals[i] = r.rnd ? int'($urandom_range(0, 511)) : (i * 20) % 512;
    end
    pushes   = 0;
    dones    = 0;
    done_cyc = -1;
    finished = 1'b0;
    for (cyc = 0; cyc < kMaxCycles; cyc++) begin
      st  = (cyc == 0) ? 1'b1 : (r.noise != 0 && phase != 0 && $urandom_range(0, 3) == 0);
      rdy = (cyc <= r.stall) ? 1'b0 : ($urandom_range(0, 99) < r.ready_pct);
      ak  = ($urandom_range(0, 99) < r.ack_pct);
      cycle(st, rdy, ak);
      if (saw_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (r.stall >= 8 && cyc == r.stall) begin
        chk("stall_acks", pushes, kFifoDepth);
        chk("stall_hs_next_low", int'(hs_next_angle), 0);
        chk("stall_has_next", int'(hs_has_next_angle), 1);
      end
      if (r.rst_after > 0 && pushes == r.rst_after) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_hs_next_angle", int'(hs_next_angle), 0);
        chk("rst_angle", int'(angle), 0);
        chk("rst_angle_valid", int'(angle_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_angle_count", int'(angle_count), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1);
        finished = 1'b1;
        break;
      end
      if (cyc > 0 && phase == 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL scan_timeout: got no end of scan expected within %0d cycles", kMaxCycles);
    end
    chk("scan_count", int'(angle_count), r.exp_count);
    chk("done_pulses", dones, (r.rst_after > 0) ? 0 : 1);
    if (r.exp_done >= 0) chk("done_cycle", done_cyc, r.exp_done);
  endtask

  initial begin
    rows[0] = '{n:4,   rnd:0, ready_pct:100, ack_pct:100, noise:0, stall:0,  rst_after:0, exp_count:4,  exp_done:7};
    rows[1] = '{n:6,   rnd:0, ready_pct:100, ack_pct:100, noise:0, stall:10, rst_after:0, exp_count:6,  exp_done:-1};
    rows[2] = '{n:0,   rnd:0, ready_pct:100, ack_pct:100, noise:0, stall:0,  rst_after:0, exp_count:0,  exp_done:3};
    rows[3] = '{n:8,   rnd:0, ready_pct:100, ack_pct:100, noise:0, stall:2,  rst_after:0, exp_count:8,  exp_done:-1};
    rows[4] = '{n:6,   rnd:0, ready_pct:100, ack_pct:100, noise:0, stall:0,  rst_after:2, exp_count:0,  exp_done:-1};
    rows[5] = '{n:10,  rnd:0, ready_pct:70,  ack_pct:70,  noise:1, stall:0,  rst_after:0, exp_count:10, exp_done:-1};
    rows[6] = '{n:40,  rnd:1, ready_pct:50,  ack_pct:60,  noise:1, stall:0,  rst_after:0, exp_count:40, exp_done:-1};
    rows[7] = '{n:260, rnd:1, ready_pct:90,  ack_pct:90,  noise:0, stall:0,  rst_after:0, exp_count:4,  exp_done:-1};
    rows[8] = '{n:25,  rnd:1, ready_pct:30,  ack_pct:40,  noise:1, stall:0,  rst_after:0, exp_count:25, exp_done:-1};

    for (int i = 0; i < 300; i++) hvals[i] = 0;
    hn = 0;
    hidx = 0;
    reset_n = 1'b0;
    start = 1'b0;
    angle_ready = 1'b0;
    hs_next_angle_ack = 1'b0;
    hs_has_next_angle = 1'b0;
    hs_angle = '0;
    model_reset();
    #12;
    chk("reset_hs_next_angle", int'(hs_next_angle), 0);
    chk("reset_angle", int'(angle), 0);
    chk("reset_angle_valid", int'(angle_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_angle_count", int'(angle_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (rows[i]) run_row(rows[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
